speed_governor: RTL and testbench
=================================

SPEED_GOVERNOR -- requirements
Module: speed_governor

Interface
REQ-001 SHALL have parameter YW, default 7, ySpeed width in bits.
REQ-002 SHALL have parameter YMAX, default 127, ySpeed ceiling; legal range CRUISE < YMAX <= 2^YW-1.
REQ-003 SHALL have parameter CRUISE, default 27, neutral ("standing still relative to road") speed.
REQ-004 SHALL have parameter STEP, default 1, ySpeed change per applied step; legal range 1..YMAX.
REQ-005 SHALL have parameter ACCEL_DIV, default 1, Enable ticks per applied longitudinal step; legal range 1..255.
REQ-006 SHALL have parameter XW, default 2, xSpeed magnitude width; parameter XMAX, default 3, magnitude ceiling, legal range 1..2^XW-1.
REQ-007 SHALL have ports: clock in 1, rising-edge clock; reset in 1, synchronous active-high reset; Enable in 1, game-tick strobe; driveEnable in 1, driving permitted; wFlag, aFlag, sFlag, dFlag in 1 each, held keys (up, left, down, right).
REQ-008 SHALL have outputs: ySpeed out YW, longitudinal speed; xSpeed out XW, lateral magnitude; xDir out 1, 1=right 0=left; moving out 1, state==RUN; atLimit out 1, ySpeed==YMAX or ySpeed==0.

Function
REQ-009 SHALL implement FSM PARK/RUN: PARK->RUN on the first cycle with driveEnable=1; RUN->PARK on any cycle with driveEnable=0.
REQ-010 SHALL, in PARK or when driveEnable=0, load ySpeed=CRUISE, xSpeed=0, xDir=0, divider=0 on the next edge, regardless of Enable.
REQ-011 SHALL change registers in RUN only on cycles with Enable=1; with Enable=0 all outputs hold.
REQ-012 SHALL keep an 8-bit divider counter: increments on each RUN Enable tick while a longitudinal action is pending; a step applies on the tick where it equals ACCEL_DIV-1, and the counter then wraps to 0; it clears to 0 on any Enable tick with no action pending.
REQ-013 SHALL treat wFlag alone as accelerate: ySpeed=min(ySpeed+STEP, YMAX) on a step tick, computed in YW+1 bits with no wrap.
REQ-014 SHALL treat sFlag alone as brake: ySpeed=max(ySpeed-STEP, 0) on a step tick, with no underflow.
REQ-015 SHALL treat wFlag and sFlag together as no action: ySpeed holds, divider clears.
REQ-016 SHALL ramp lateral motion on each RUN Enable tick: dFlag alone sets xDir=1; aFlag alone sets xDir=0; same direction as the previous tick gives xSpeed=min(xSpeed+1, XMAX); reversal or start from 0 gives xSpeed=1.
REQ-017 SHALL set xSpeed=0 (xDir holds) when neither or both of aFlag/dFlag are held.
REQ-018 SHALL force xSpeed=0 whenever the ySpeed value resulting from the same tick equals CRUISE, overriding REQ-016.
REQ-019 SHALL drive moving and atLimit combinationally from registered state, with zero latency.

Reset
REQ-020 SHALL, on reset=1 at a clock edge, set state=PARK, ySpeed=CRUISE, xSpeed=0, xDir=0, divider=0; reset overrides every other input, including mid-step.

Configuration
REQ-021 SHALL, with macro SPEED_GOVERNOR_COAST_EN defined, treat "neither or both of wFlag/sFlag" in RUN with ySpeed!=CRUISE as a pending coast action: on a step tick ySpeed moves STEP toward CRUISE, clamped so it never crosses CRUISE.
REQ-022 SHALL, without SPEED_GOVERNOR_COAST_EN, behave exactly as REQ-015 (ySpeed holds); no coast logic is synthesised.

Structure
REQ-023 SHALL place the PARK/RUN state enum and the default parameter constants in a shared package speed_pkg.
REQ-024 SHALL implement the divider (REQ-012) as sub-module tick_divider (inputs clear, advance; output fire; parameter DIV).

Verification
REQ-025 Reset, then driveEnable=1, wFlag=1 held for 5 Enable ticks (defaults) -> ySpeed 27->32, xSpeed=0, moving=1.
REQ-026 ACCEL_DIV=4, STEP=3, wFlag held for 8 Enable ticks -> ySpeed 27->30 on tick 4 and 30->33 on tick 8; ySpeed=126 then a step -> 127 and atLimit=1.
REQ-027 ySpeed=1, sFlag held 3 ticks -> 0,0,0 with atLimit=1; w+s held together -> no ySpeed change.
REQ-028 ySpeed=40, dFlag held 4 ticks -> xSpeed 1,2,3,3 with xDir=1; then aFlag -> xSpeed=1, xDir=0; ySpeed=28 with sFlag+dFlag -> ySpeed=27, xSpeed=0.
REQ-029 COAST_EN defined, ySpeed=30, STEP=2, no keys -> 28, 27, 27; undefined -> 30 holds.
REQ-030 Mid-acceleration, driveEnable=0 for 1 cycle -> ySpeed=27, divider=0, moving=0; reset=1 with Enable=1 and wFlag=1 -> reset values.

Source files
------------

// File: rtl/speed_pkg.sv
// Shared state enum and default parameter constants for the speed governor.
package speed_pkg;

    typedef enum logic {
        StPark = 1'b0,
        StRun  = 1'b1
    } gov_state_e;

    localparam int unsigned YwDef       = 7;
    localparam int unsigned YmaxDef     = 127;
    localparam int unsigned CruiseDef   = 27;
    localparam int unsigned StepDef     = 1;
    localparam int unsigned AccelDivDef = 1;
    localparam int unsigned XwDef       = 2;
    localparam int unsigned XmaxDef     = 3;
    localparam int unsigned DivW        = 8;

endpackage

// File: rtl/tick_divider.sv
// Counts advance pulses and fires on every DIV-th one; clear restarts the count.
module tick_divider
    import speed_pkg::*;
#(
    parameter int unsigned DIV = AccelDivDef
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic advance,
    output logic fire
);

    localparam logic [DivW-1:0] LastCnt = DivW'(DIV - 1);

    logic [DivW-1:0] cnt_q, cnt_d;

    always_comb begin
        fire  = advance && (cnt_q == LastCnt);
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (advance) begin
            cnt_d = fire ? '0 : cnt_q + DivW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/speed_governor.sv
// Longitudinal/lateral speed governor with PARK/RUN control.
// Optional macro SPEED_GOVERNOR_COAST_EN: with no longitudinal key, drift ySpeed back to CRUISE.
module speed_governor
    import speed_pkg::*;
#(
    parameter int unsigned YW        = YwDef,
    parameter int unsigned YMAX      = YmaxDef,
    parameter int unsigned CRUISE    = CruiseDef,
    parameter int unsigned STEP      = StepDef,
    parameter int unsigned ACCEL_DIV = AccelDivDef,
    parameter int unsigned XW        = XwDef,
    parameter int unsigned XMAX      = XmaxDef
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          Enable,
    input  logic          driveEnable,
    input  logic          wFlag,
    input  logic          aFlag,
    input  logic          sFlag,
    input  logic          dFlag,
    output logic [YW-1:0] ySpeed,
    output logic [XW-1:0] xSpeed,
    output logic          xDir,
    output logic          moving,
    output logic          atLimit
);

    localparam logic [YW:0]   StepW   = (YW + 1)'(STEP);
    localparam logic [YW-1:0] YmaxY   = YW'(YMAX);
    localparam logic [YW-1:0] CruiseY = YW'(CRUISE);
    localparam logic [XW-1:0] XmaxX   = XW'(XMAX);

    gov_state_e    state_q, state_d;
    logic [YW-1:0] y_q, y_d;
    logic [XW-1:0] x_q, x_d;
    logic          dir_q, dir_d;

    logic          park_load, run_tick;
    logic          accel, brake, pending;
    logic          div_clear, div_advance, div_fire;
    logic [YW:0]   y_up;
    logic [YW-1:0] y_up_sat, y_dn, y_step;
    logic [XW-1:0] x_step;
    logic          dir_step;

`ifdef SPEED_GOVERNOR_COAST_EN
    logic          coast;
    logic [YW-1:0] coast_gap, y_coast;
`endif

    // Parked or driving withheld: everything reloads regardless of Enable.
    assign park_load = (state_q == StPark) || !driveEnable;
    assign run_tick  = !park_load && Enable;
    assign accel     = wFlag && !sFlag;
    assign brake     = sFlag && !wFlag;

`ifdef SPEED_GOVERNOR_COAST_EN
    assign coast   = (wFlag == sFlag) && (y_q != CruiseY);
    assign pending = accel || brake || coast;
`else
    assign pending = accel || brake;
`endif

    assign div_clear   = park_load || (run_tick && !pending);
    assign div_advance = run_tick && pending;

    tick_divider #(
        .DIV(ACCEL_DIV)
    ) u_tick_divider (
        .clock  (clock),
        .reset  (reset),
        .clear  (div_clear),
        .advance(div_advance),
        .fire   (div_fire)
    );

    always_comb begin
        y_up     = {1'b0, y_q} + StepW;
        y_up_sat = (y_up > {1'b0, YmaxY}) ? YmaxY : y_up[YW-1:0];
        y_dn     = ({1'b0, y_q} < StepW) ? '0 : y_q - StepW[YW-1:0];
`ifdef SPEED_GOVERNOR_COAST_EN
        // Snap to CRUISE when one step would reach or cross it.
        if (y_q > CruiseY) begin
            coast_gap = y_q - CruiseY;
            y_coast   = ({1'b0, coast_gap} <= StepW) ? CruiseY : y_dn;
        end else begin
            coast_gap = CruiseY - y_q;
            y_coast   = ({1'b0, coast_gap} <= StepW) ? CruiseY : y_up_sat;
        end
`endif
        y_step = y_q;
        if (div_fire) begin
            if (accel) begin
                y_step = y_up_sat;
            end else if (brake) begin
                y_step = y_dn;
            end
`ifdef SPEED_GOVERNOR_COAST_EN
            else if (coast) begin
                y_step = y_coast;
            end
`endif
        end
    end

    always_comb begin
        dir_step = dir_q;
        x_step   = '0;
        if (aFlag ^ dFlag) begin
            dir_step = dFlag;
            if ((x_q != '0) && (dir_q == dFlag)) begin
                x_step = (x_q >= XmaxX) ? XmaxX : x_q + XW'(1);
            end else begin
                x_step = XW'(1);
            end
        end
        // No lateral drift while matching road speed.
        if (y_step == CruiseY) begin
            x_step = '0;
        end
    end

    always_comb begin
        state_d = driveEnable ? StRun : StPark;
        y_d     = y_q;
        x_d     = x_q;
        dir_d   = dir_q;
        if (park_load) begin
            y_d   = CruiseY;
            x_d   = '0;
            dir_d = 1'b0;
        end else if (run_tick) begin
            y_d   = y_step;
            x_d   = x_step;
            dir_d = dir_step;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StPark;
            y_q     <= CruiseY;
            x_q     <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            x_q     <= x_d;
            dir_q   <= dir_d;
        end
    end

    assign ySpeed  = y_q;
    assign xSpeed  = x_q;
    assign xDir    = dir_q;
    assign moving  = (state_q == StRun);
    assign atLimit = (y_q == YmaxY) || (y_q == '0);

endmodule

// File: tb/tb_speed_governor.sv
// Directed bench for speed_governor: a vector table on a default instance plus
// hand sequences on a divided/stepped instance and a low-ceiling coast instance.
module tb_speed_governor;

    logic clock = 1'b0;
    logic reset, Enable, driveEnable, wFlag, aFlag, sFlag, dFlag;

    logic [6:0] y0, y1, y2;
    logic [1:0] x0, x1, x2;
    logic       dir0, dir1, dir2, mov0, mov1, mov2, lim0, lim1, lim2;

    int total = 0;
    int bad   = 0;

    localparam logic [3:0] KN = 4'b0000;
    localparam logic [3:0] KW = 4'b1000;
    localparam logic [3:0] KA = 4'b0100;
    localparam logic [3:0] KS = 4'b0010;
    localparam logic [3:0] KD = 4'b0001;

    always #5 clock = ~clock;

    speed_governor u_dut0 (
        .clock(clock), .reset(reset), .Enable(Enable), .driveEnable(driveEnable),
        .wFlag(wFlag), .aFlag(aFlag), .sFlag(sFlag), .dFlag(dFlag),
        .ySpeed(y0), .xSpeed(x0), .xDir(dir0), .moving(mov0), .atLimit(lim0)
    );

    speed_governor #(.STEP(3), .ACCEL_DIV(4)) u_dut1 (
        .clock(clock), .reset(reset), .Enable(Enable), .driveEnable(driveEnable),
        .wFlag(wFlag), .aFlag(aFlag), .sFlag(sFlag), .dFlag(dFlag),
        .ySpeed(y1), .xSpeed(x1), .xDir(dir1), .moving(mov1), .atLimit(lim1)
    );

    speed_governor #(.YMAX(30), .STEP(2)) u_dut2 (
        .clock(clock), .reset(reset), .Enable(Enable), .driveEnable(driveEnable),
        .wFlag(wFlag), .aFlag(aFlag), .sFlag(sFlag), .dFlag(dFlag),
        .ySpeed(y2), .xSpeed(x2), .xDir(dir2), .moving(mov2), .atLimit(lim2)
    );

    typedef struct {
        logic       rst;
        logic       de;
        logic       en;
        logic [3:0] k;
        int         y;
        int         x;
        int         dir;
        int         mov;
        int         lim;
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic rst, logic de, logic en, logic [3:0] k,
                                int y, int x, int dir, int mov, int lim);
        vec_t v;
        v.rst = rst; v.de = de; v.en = en; v.k = k;
        v.y = y; v.x = x; v.dir = dir; v.mov = mov; v.lim = lim;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic rst, input logic de, input logic en, input logic [3:0] k);
        @(negedge clock);
        reset = rst; driveEnable = de; Enable = en;
        wFlag = k[3]; aFlag = k[2]; sFlag = k[1]; dFlag = k[0];
        @(posedge clock);
        #1;
    endtask

    initial begin
        int exp_a[8];
        int coast_exp[3];

        reset = 1'b1; driveEnable = 1'b0; Enable = 1'b0;
        wFlag = 1'b0; aFlag = 1'b0; sFlag = 1'b0; dFlag = 1'b0;

        // rst de en keys      y  x dir mov lim
        add(1, 0, 0, KN,      27, 0, 0, 0, 0);
        add(0, 1, 1, KW,      27, 0, 0, 1, 0);
        for (int i = 1; i <= 5; i++) add(0, 1, 1, KW, 27 + i, 0, 0, 1, 0);
        add(0, 1, 0, KW,      32, 0, 0, 1, 0);
        add(0, 1, 1, KW | KS, 32, 0, 0, 1, 0);
        for (int i = 1; i <= 8; i++) add(0, 1, 1, KW, 32 + i, 0, 0, 1, 0);
        add(0, 1, 1, KD,      40, 1, 1, 1, 0);
        add(0, 1, 1, KD,      40, 2, 1, 1, 0);
        add(0, 1, 1, KD,      40, 3, 1, 1, 0);
        add(0, 1, 1, KD,      40, 3, 1, 1, 0);
        add(0, 1, 1, KA,      40, 1, 0, 1, 0);
        add(0, 1, 1, KN,      40, 0, 0, 1, 0);
        for (int i = 1; i <= 12; i++) add(0, 1, 1, KS, 40 - i, 0, 0, 1, 0);
        add(0, 1, 1, KS | KD, 27, 0, 1, 1, 0);
        for (int i = 1; i <= 26; i++) add(0, 1, 1, KS, 27 - i, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 1, KS, 0, 0, 1, 1, 1);
        add(0, 1, 1, KW | KS, 0, 0, 1, 1, 1);
        add(0, 1, 1, KW,       1, 0, 1, 1, 0);
        add(0, 0, 1, KW,      27, 0, 0, 0, 0);
        add(0, 1, 1, KW,      27, 0, 0, 1, 0);
        add(0, 1, 1, KW,      28, 0, 0, 1, 0);
        add(1, 1, 1, KW,      27, 0, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst, vq[i].de, vq[i].en, vq[i].k);
            check($sformatf("v%0d.ySpeed", i), int'(y0), vq[i].y);
            check($sformatf("v%0d.xSpeed", i), int'(x0), vq[i].x);
            check($sformatf("v%0d.xDir", i), int'(dir0), vq[i].dir);
            check($sformatf("v%0d.moving", i), int'(mov0), vq[i].mov);
            check($sformatf("v%0d.atLimit", i), int'(lim0), vq[i].lim);
        end

        // Divided acceleration: STEP=3 every 4th tick, then saturate at 127.
        step(1, 0, 0, KN);
        step(0, 1, 0, KN);
        check("div.moving", int'(mov1), 1);
        exp_a = '{27, 27, 27, 30, 30, 30, 30, 33};
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, KW);
            check($sformatf("div.tick%0d", i + 1), int'(y1), exp_a[i]);
        end
        for (int i = 0; i < 124; i++) step(0, 1, 1, KW);
        check("div.y126", int'(y1), 126);
        check("div.lim126", int'(lim1), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, KW);
        check("div.pre_sat", int'(y1), 126);
        step(0, 1, 1, KW);
        check("div.sat", int'(y1), 127);
        check("div.sat_lim", int'(lim1), 1);

        // No action pending clears the divider.
        step(1, 0, 0, KN);
        step(0, 1, 0, KN);
        step(0, 1, 1, KW);
        step(0, 1, 1, KW);
        step(0, 1, 1, KN);
        for (int i = 0; i < 3; i++) step(0, 1, 1, KW);
        check("clr.hold", int'(y1), 27);
        step(0, 1, 1, KW);
        check("clr.fire", int'(y1), 30);

        // driveEnable dropped mid-count parks and clears the divider.
        step(1, 0, 0, KN);
        step(0, 1, 0, KN);
        step(0, 1, 1, KW);
        step(0, 1, 1, KW);
        step(0, 0, 1, KW);
        check("drop.y", int'(y1), 27);
        check("drop.moving", int'(mov1), 0);
        step(0, 1, 1, KW);
        check("drop.rerun_y", int'(y1), 27);
        check("drop.rerun_mov", int'(mov1), 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, KW);
        check("drop.hold", int'(y1), 27);
        step(0, 1, 1, KW);
        check("drop.fire", int'(y1), 30);

        // Enable low freezes the divider count.
        step(1, 0, 0, KN);
        step(0, 1, 0, KN);
        for (int i = 0; i < 3; i++) step(0, 1, 1, KW);
        step(0, 1, 0, KW);
        check("en0.hold", int'(y1), 27);
        step(0, 1, 1, KW);
        check("en0.fire", int'(y1), 30);

        // Reset on what would be the firing tick.
        step(1, 0, 0, KN);
        step(0, 1, 0, KN);
        for (int i = 0; i < 3; i++) step(0, 1, 1, KW);
        step(1, 1, 1, KW);
        check("rst.y", int'(y1), 27);
        check("rst.moving", int'(mov1), 0);
        step(0, 1, 1, KW);
        for (int i = 0; i < 3; i++) step(0, 1, 1, KW);
        check("rst.hold", int'(y1), 27);
        step(0, 1, 1, KW);
        check("rst.fire", int'(y1), 30);

        // Coast from 30 toward CRUISE with STEP=2 (ceiling 30 on this instance).
        step(1, 0, 0, KN);
        step(0, 1, 0, KN);
        step(0, 1, 1, KW);
        check("cst.y29", int'(y2), 29);
        step(0, 1, 1, KW);
        check("cst.y30", int'(y2), 30);
        check("cst.lim", int'(lim2), 1);
`ifdef SPEED_GOVERNOR_COAST_EN
        coast_exp = '{28, 27, 27};
`else
        coast_exp = '{30, 30, 30};
`endif
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, KN);
            check($sformatf("cst.tick%0d", i + 1), int'(y2), coast_exp[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
